// File: rtl/pc_unit_pkg.sv
// Shared encodings for the KGP-miniRISC program-counter unit.
package pc_unit_pkg;
   localparam logic [2:0] OP_SEQ     = 3'd0;
   localparam logic [2:0] OP_BR_REL  = 3'd1;
   localparam logic [2:0] OP_JMP_ABS = 3'd2;
   localparam logic [2:0] OP_CALL    = 3'd3;
   localparam logic [2:0] OP_RET     = 3'd4;

   typedef enum logic {ST_RUN, ST_HALT} state_t;
endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack; a push when full overwrites the oldest entry.
module pc_ras #(
   parameter int ADDR_W    = 32,
   parameter int RAS_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push,
   input  logic              pop,
   input  logic [ADDR_W-1:0] din,
   output logic [ADDR_W-1:0] dout,
   output logic              empty,
   output logic              full
);
   localparam int PTR_W = $clog2(RAS_DEPTH);
   localparam logic [PTR_W-1:0] PTR_ONE = 1;
   localparam logic [PTR_W:0]   CNT_ONE = 1;
   localparam logic [PTR_W:0]   CNT_MAX = RAS_DEPTH[PTR_W:0];

   logic [ADDR_W-1:0] mem [RAS_DEPTH];
   logic [PTR_W-1:0]  wptr;
   logic [PTR_W:0]    count;

   assign empty = (count == '0);
   assign full  = (count == CNT_MAX);
   // wptr is the next free slot, so the top sits one below it
   assign dout  = mem[wptr - PTR_ONE];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr  <= '0;
         count <= '0;
      end else if (push) begin
         wptr  <= wptr + PTR_ONE;
         count <= full ? count : count + CNT_ONE;
      end else if (pop && !empty) begin
         wptr  <= wptr - PTR_ONE;
         count <= count - CNT_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wptr] <= din;
   end
endmodule

// File: rtl/pc_unit.sv
// Registered program counter with relative/absolute branches, call/return
// through a small RAS, stall and a reset-only-exit halt state.
module pc_unit
   import pc_unit_pkg::*;
#(
   parameter int                ADDR_W    = 32,
   parameter int                STEP      = 1,
   parameter logic [ADDR_W-1:0] RESET_VEC = '0,
   parameter int                RAS_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              stall,
   input  logic              halt,
   input  logic [2:0]        op,
   input  logic              br_taken,
   input  logic [ADDR_W-1:0] offset,
   input  logic [ADDR_W-1:0] target,
   output logic [ADDR_W-1:0] pc,
   output logic [ADDR_W-1:0] pc_next_seq,
   output logic              halted,
   output logic              ras_ovf,
   output logic              ras_unf
);
   state_t            state, state_n;
   logic [ADDR_W-1:0] pc_n;
   logic              ovf_n, unf_n;
   logic              push, pop;
   logic [ADDR_W-1:0] ras_top;
   logic              ras_empty, ras_full;

   assign pc_next_seq = pc + ADDR_W'(STEP);

   pc_ras #(.ADDR_W(ADDR_W), .RAS_DEPTH(RAS_DEPTH)) u_ras (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .pop   (pop),
      .din   (pc_next_seq),
      .dout  (ras_top),
      .empty (ras_empty),
      .full  (ras_full)
   );

   always_comb begin
      state_n = state;
      pc_n    = pc;
      ovf_n   = ras_ovf;
      unf_n   = ras_unf;
      push    = 1'b0;
      pop     = 1'b0;
      if (state == ST_RUN) begin
         if (halt) begin
            state_n = ST_HALT;
         end else if (!stall) begin
            case (op)
               OP_BR_REL:  pc_n = br_taken ? pc_next_seq + offset : pc_next_seq;
               OP_JMP_ABS: pc_n = target;
               OP_CALL: begin
                  pc_n = target;
                  push = 1'b1;
                  if (ras_full) ovf_n = 1'b1;
               end
               OP_RET: begin
                  if (ras_empty) begin
                     pc_n  = pc_next_seq;
                     unf_n = 1'b1;
                  end else begin
                     pc_n = ras_top;
                     pop  = 1'b1;
                  end
               end
               default:    pc_n = pc_next_seq;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_RUN;
         pc      <= RESET_VEC;
         ras_ovf <= 1'b0;
         ras_unf <= 1'b0;
      end else begin
         state   <= state_n;
         pc      <= pc_n;
         ras_ovf <= ovf_n;
         ras_unf <= unf_n;
      end
   end

   assign halted = (state == ST_HALT);
endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit for the KGP-miniRISC fetch stage. It replaces the bare combinational PC incrementer with a registered PC that supports:
- a configurable step;
- conditional relative branches, absolute jumps, and call/return through a small return-address stack (RAS);
- stall and halt control.

The instruction-memory address is driven directly from `pc`.

## Interface
- `ADDR_W`, 32, PC/address width in bits.
- `STEP`, 1, sequential increment (word-addressed memory ⇒ 1).
- `RESET_VEC`, 0, PC value after reset.
- `RAS_DEPTH`, 4, return-address stack entries (≥2, power of two).
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `stall`  in  1  hold PC and RAS this cycle.
- `halt`  in  1  enter HALT state; only reset leaves it.
- `op`  in  3  next-PC operation: 0 SEQ, 1 BR_REL, 2 JMP_ABS, 3 CALL, 4 RET; codes 5–7 behave as SEQ.
- `br_taken`  in  1  condition result for BR_REL.
- `offset`  in  ADDR_W  signed two's-complement branch offset.
- `target`  in  ADDR_W  absolute target for JMP_ABS/CALL.
- `pc`  out  ADDR_W  current PC (registered).
- `pc_next_seq`  out  ADDR_W  `pc + STEP` (combinational; link value).
- `halted`  out  1  registered; 1 in HALT state.
- `ras_ovf`  out  1  sticky; a push occurred while the RAS was full.
- `ras_unf`  out  1  sticky; a pop occurred while the RAS was empty.

## Operation
- States: RUN, HALT.
  - RUN → HALT when `halt`=1 at a clock edge.
  - HALT → RUN only via `rst_n`.
  - In HALT, `pc`, the RAS and the flags are frozen and all inputs are ignored.
- Priority at each edge: `halt` > `stall` > `op`.
  - With `halt`=1, `pc` does not update on that edge.
  - With `stall`=1, `pc` and the RAS hold and `op` is ignored, so no push or pop occurs.
- Next PC in RUN with no stall:
  - SEQ: `pc+STEP`.
  - BR_REL: `pc+STEP+offset` if `br_taken`, else `pc+STEP`.
  - JMP_ABS: `target`.
  - CALL: `target`; push `pc+STEP`.
  - RET: pop the top entry; if the RAS is empty, use `pc+STEP` and set `ras_unf`.
- Arithmetic: all sums are modulo 2^ADDR_W; wrap-around is silent, with no flag. `offset` is added as an ADDR_W-bit value, so its sign is implicit.
- RAS behaviour:
  - It is circular, with a write pointer and an occupancy count saturating at RAS_DEPTH.
  - Push when full overwrites the oldest entry, keeps count=RAS_DEPTH, and sets `ras_ovf`.
  - Pop when empty leaves the pointer and count unchanged.
  - Pushes and pops happen only on CALL and RET respectively, so the two never coincide in one cycle.
- Sticky flags clear only on reset.

## Timing
- Reset (asynchronous, while `rst_n`=0):
  - `pc`=RESET_VEC, `halted`=0, `ras_ovf`=0, `ras_unf`=0;
  - RAS count=0, pointer=0;
  - state RUN.
  - Reset asserted mid-operation, including in HALT, takes effect immediately with no clock needed.
- Reset release: first update at the first rising edge after `rst_n` rises.
- Latency:
  - `op`/`target`/`offset` sampled at edge N appear on `pc` after edge N.
  - `pc_next_seq` follows `pc` combinationally in the same cycle.
- `halted` rises after the edge that samples `halt`=1.
- CALL immediately followed by RET (back-to-back cycles) returns to the CALL's `pc+STEP`; no bypass hazard exists because the push is registered before the pop cycle.

## Structure
- Package `pc_unit_pkg`: op encodings (`OP_SEQ`…`OP_RET`) and the state enum (`ST_RUN`, `ST_HALT`).
- Sub-module `pc_ras`:
  - Parameters ADDR_W and RAS_DEPTH.
  - Ports: `clk`, `rst_n`, `push`, `pop`, `din`, `dout`, `empty`, `full`.
  - `dout` is the combinational top-of-stack.
- The top level holds the PC register, the state register, next-PC mux and the flags.

## Test plan
- Reset/SEQ: `rst_n` low with RESET_VEC=0x10, then release and apply SEQ for 3 cycles → `pc` = 0x10, 0x11, 0x12, 0x13; `pc_next_seq` is always `pc+1`.
- Branch: at `pc`=0x20, BR_REL with `offset`=-5 and `br_taken`=1 → `pc`=0x1C. Same with `br_taken`=0 → 0x21. At `pc`=0xFFFFFFFF, SEQ → `pc`=0x00000000.
- Call/return: CALL `target`=0x100 from `pc`=0x40, then CALL 0x200, then RET, RET → `pc` = 0x100, 0x200, 0x101, 0x41; no flags set.
- RAS boundaries (RAS_DEPTH=4):
  - 5 nested CALLs → `ras_ovf`=1.
  - Then 4 RETs → return addresses of calls 5, 4, 3, 2 in that order.
  - A 5th RET → `pc+1` and `ras_unf`=1.
- Stall/halt:
  - `stall`=1 together with CALL → `pc` and RAS unchanged.
  - `halt`=1 together with `stall`=1 → `halted`=1 and `pc` frozen thereafter.
  - Pulse `rst_n` low mid-cycle → `pc`=RESET_VEC and `halted`=0 without a clock edge.
